key_seq_controller: RTL

- Parametrised successor to the single-key Controller FSM.
- Accepts a multi-key entry sequence on InputKey, one key per ValidCmd rising edge.
- Compares the sequence against a programmable user code and a fixed master code.
- Asserts Active and Mode on a match, counts failed attempts, locks out after repeated failures, abandons idle partial entries, and lets the master user reprogram the user code.

---
 rtl/key_seq_controller_if.sv | 33 +++
 rtl/key_seq_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/key_seq_controller_if.sv
// key_seq_controller_if
//   Groups the key-entry, control and status signals of key_seq_controller.
//   master : drives keys/controls, observes status (bench or host side)
//   slave  : the controller itself
//   InputKey/ValidCmd : key value and key-valid level
//   Logout/ProgEn/ProgCode : session exit and user-code programming
//   Active/Mode/Locked/FailCnt/State : registered status
interface key_seq_controller_if #(
   parameter int unsigned KEY_W    = 5,
   parameter int unsigned SEQ_LEN  = 3,
   parameter int unsigned MAX_FAIL = 3
);
   logic [KEY_W-1:0]               InputKey;
   logic                           ValidCmd;
   logic                           Logout;
   logic                           ProgEn;
   logic [KEY_W*SEQ_LEN-1:0]       ProgCode;
   logic                           Active;
   logic                           Mode;
   logic                           Locked;
   logic [$clog2(MAX_FAIL+1)-1:0]  FailCnt;
   logic [1:0]                     State;

   modport master (
      output InputKey, ValidCmd, Logout, ProgEn, ProgCode,
      input  Active, Mode, Locked, FailCnt, State
   );

   modport slave (
      input  InputKey, ValidCmd, Logout, ProgEn, ProgCode,
      output Active, Mode, Locked, FailCnt, State
   );
endinterface

// File: rtl/key_seq_controller.sv
// key_seq_controller
//   Multi-key access controller. Keys arrive one per ValidCmd rising edge and
//   are matched against a programmable user code and a fixed master code.
//   A full match grants access (Mode=1 master, Mode=0 user); failed sequences
//   are counted and MAX_FAIL consecutive failures lock the block for
//   LOCK_CYCLES cycles. Partial entries idle for TIMEOUT cycles are dropped.
//   Ports:
//     Clk   : system clock, rising edge
//     Reset : asynchronous, active-low
//     bus   : key_seq_controller_if slave modport (keys, controls, status)
module key_seq_controller #(
   parameter int unsigned             KEY_W        = 5,
   parameter int unsigned             SEQ_LEN      = 3,
   parameter logic [KEY_W*SEQ_LEN-1:0] DEFAULT_CODE = {5'b10000, 5'b00101, 5'b00001},
   parameter logic [KEY_W*SEQ_LEN-1:0] MASTER_CODE  = {3{5'b10101}},
   parameter int unsigned             MAX_FAIL     = 3,
   parameter int unsigned             LOCK_CYCLES  = 16,
   parameter int unsigned             TIMEOUT      = 32
) (
   input logic                  Clk,
   input logic                  Reset,
   key_seq_controller_if.slave  bus
);

   localparam int unsigned CW = KEY_W * SEQ_LEN;
   localparam int unsigned IW = $clog2(SEQ_LEN + 1);
   localparam int unsigned FW = $clog2(MAX_FAIL + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

   localparam logic [IW-1:0] LAST_IDX = IW'(SEQ_LEN - 1);
   localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [LW-1:0] LK_LAST  = LW'(LOCK_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ENTRY  = 2'b01,
      ACTIVE = 2'b10,
      LOCKED = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic            vq_q;
   logic [IW-1:0]   idx_q, idx_d;
   logic            um_q, um_d;
   logic            mm_q, mm_d;
   logic [FW-1:0]   fail_q, fail_d;
   logic            mode_q, mode_d;
   logic [CW-1:0]   code_q, code_d;
   logic [TW-1:0]   idle_q, idle_d;
   logic [LW-1:0]   lock_q, lock_d;

   logic            strobe;
   logic [KEY_W-1:0] user_key, master_key;
   logic            hit_u, hit_m;
   logic            fin_u, fin_m;
   logic [FW-1:0]   fail_inc;

   assign strobe   = bus.ValidCmd & ~vq_q;
   assign hit_u    = (bus.InputKey == user_key);
   assign hit_m    = (bus.InputKey == master_key);
   assign fin_u    = um_q & hit_u;
   assign fin_m    = mm_q & hit_m;
   assign fail_inc = fail_q + FW'(1);

   // Expected key for the current position; idx_q is 0 in IDLE.
   always_comb begin
      user_key   = '0;
      master_key = '0;
      for (int unsigned i = 0; i < SEQ_LEN; i++) begin
         if (idx_q == IW'(i)) begin
            user_key   = code_q[i*KEY_W +: KEY_W];
            master_key = MASTER_CODE[i*KEY_W +: KEY_W];
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         vq_q    <= 1'b0;
         idx_q   <= '0;
         um_q    <= 1'b0;
         mm_q    <= 1'b0;
         fail_q  <= '0;
         mode_q  <= 1'b0;
         code_q  <= DEFAULT_CODE;
         idle_q  <= '0;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         vq_q    <= bus.ValidCmd;
         idx_q   <= idx_d;
         um_q    <= um_d;
         mm_q    <= mm_d;
         fail_q  <= fail_d;
         mode_q  <= mode_d;
         code_q  <= code_d;
         idle_q  <= idle_d;
         lock_q  <= lock_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      um_d    = um_q;
      mm_d    = mm_q;
      fail_d  = fail_q;
      mode_d  = mode_q;
      code_d  = code_q;
      idle_d  = idle_q;
      lock_d  = lock_q;

      unique case (state_q)
         IDLE: begin
            if (strobe) begin
               um_d    = hit_u;
               mm_d    = hit_m;
               idx_d   = IW'(1);
               idle_d  = '0;
               state_d = ENTRY;
            end
         end

         ENTRY: begin
            if (strobe) begin
               idle_d = '0;
               if (idx_q == LAST_IDX) begin
                  // Decision uses the final key's comparison folded in directly.
                  idx_d = '0;
                  if (fin_m) begin
                     state_d = ACTIVE;
                     mode_d  = 1'b1;
                     fail_d  = '0;
                  end else if (fin_u) begin
                     state_d = ACTIVE;
                     mode_d  = 1'b0;
                     fail_d  = '0;
                  end else begin
                     fail_d = fail_inc;
                     if (fail_inc == FAIL_MAX) begin
                        state_d = LOCKED;
                        lock_d  = '0;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end else begin
                  idx_d = idx_q + IW'(1);
                  um_d  = fin_u;
                  mm_d  = fin_m;
               end
            end else if (idle_q == TO_LAST) begin
               state_d = IDLE;
               idx_d   = '0;
               idle_d  = '0;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end

         ACTIVE: begin
            if (bus.ProgEn && mode_q) begin
               code_d = bus.ProgCode;
            end
            if (bus.Logout) begin
               state_d = IDLE;
               mode_d  = 1'b0;
            end
         end

         LOCKED: begin
            if (lock_q == LK_LAST) begin
               state_d = IDLE;
               fail_d  = '0;
               lock_d  = '0;
            end else begin
               lock_d = lock_q + LW'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.Active  = (state_q == ACTIVE);
   assign bus.Locked  = (state_q == LOCKED);
   assign bus.Mode    = mode_q;
   assign bus.FailCnt = fail_q;
   assign bus.State   = state_q;

endmodule
